cheat_loader: RTL and testbench

Initiator side of the cheat engine's program port (`pgm_idx`/`pgm_we`/`pgm_in`). The block sits between the MCU command byte stream and the cheat/hook block. It assembles MCU bytes into 32-bit program words and issues single-cycle write strobes. It never issues a strobe in a cycle where the SNES command path would win the cheat block's register-write priority, because that write would be dropped.

---
 rtl/cheat_loader_pkg.sv | 44 ++++
 rtl/cheat_loader_shadow.sv | 53 +++++
 rtl/cheat_loader.sv | 159 +++++++++++++++
 tb/tb_cheat_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheat_loader_pkg.sv
// Shared encodings for the cheat program-port loader: FSM states, special
// register indices and the program-word field layout.
package cheat_loader_pkg;

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_D0    = 3'd1;
  localparam logic [2:0] ST_D1    = 3'd2;
  localparam logic [2:0] ST_D2    = 3'd3;
  localparam logic [2:0] ST_D3    = 3'd4;
  localparam logic [2:0] ST_ISSUE = 3'd5;
  localparam logic [2:0] ST_FLUSH = 3'd6;

  localparam int IDX_MASK  = 6;
  localparam int IDX_FLAGS = 7;

  // Slot word: {addr[23:0], data[7:0]}. Flags word: clear bits and set bits.
  localparam int SLOT_ADDR_MSB = 31;
  localparam int SLOT_ADDR_LSB = 8;
  localparam int SLOT_DATA_MSB = 7;
  localparam int SLOT_DATA_LSB = 0;
  localparam int FLAG_CLR_MSB  = 13;
  localparam int FLAG_CLR_LSB  = 8;
  localparam int FLAG_SET_MSB  = 5;
  localparam int FLAG_SET_LSB  = 0;

  function automatic logic [31:0] make_slot_word(input logic [23:0] addr,
                                                 input logic [7:0]  data);
    logic [31:0] w;
    w = '0;
    w[SLOT_ADDR_MSB:SLOT_ADDR_LSB] = addr;
    w[SLOT_DATA_MSB:SLOT_DATA_LSB] = data;
    return w;
  endfunction

  function automatic logic [31:0] make_flags_word(input logic [5:0] clr_bits,
                                                  input logic [5:0] set_bits);
    logic [31:0] w;
    w = '0;
    w[FLAG_CLR_MSB:FLAG_CLR_LSB] = clr_bits;
    w[FLAG_SET_MSB:FLAG_SET_LSB] = set_bits;
    return w;
  endfunction

endpackage

// File: rtl/cheat_loader_shadow.sv
// Shadow store for atomic slot updates: SLOTS program words, per-slot valid
// bits and a lowest-valid-index scan. Used only with CHEAT_LOADER_ATOMIC_EN.
module cheat_loader_shadow
  import cheat_loader_pkg::*;
#(
  parameter int SLOTS = IDX_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic        clr_en,
  input  logic [2:0]  clr_idx,
  output logic        any_valid,
  output logic [2:0]  first_idx,
  output logic [31:0] first_data
);

  logic [31:0]      mem [SLOTS];
  logic [SLOTS-1:0] valid_q;

  // NOTE: the word storage has no reset; the valid bits alone decide whether
  // an entry is meaningful, so clearing them is sufficient.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    first_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        any_valid = 1'b1;
        first_idx = 3'(i);
      end
    end
  end

  assign first_data = mem[first_idx];

endmodule

// File: rtl/cheat_loader.sv
// Assembles MCU header+4 data bytes into cheat program words and issues
// single-cycle pgm_we strobes that never collide with snes_busy.
// Define CHEAT_LOADER_ATOMIC_EN to buffer slot words and flush them atomically.
module cheat_loader
  import cheat_loader_pkg::*;
#(
  parameter int SLOTS = IDX_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mcu_start,
  input  logic        mcu_valid,
  input  logic [7:0]  mcu_data,
  output logic        mcu_ready,
  input  logic        snes_busy,
  output logic [2:0]  pgm_idx,
  output logic [31:0] pgm_in,
  output logic        pgm_we,
  output logic        err
);

  logic [2:0]  state_q;
  logic [2:0]  hdr_idx_q;
  logic [23:0] shift_q;
  logic        accept;
  logic [31:0] word_full;

  assign mcu_ready = (state_q <= ST_D3);
  assign accept    = mcu_valid && mcu_ready && !mcu_start;
  assign word_full = make_slot_word(shift_q, mcu_data);
  // The strobe is gated by the live busy input so a cheat-block write is never dropped.
  assign pgm_we    = ((state_q == ST_ISSUE) || (state_q == ST_FLUSH)) && !snes_busy;

`ifdef CHEAT_LOADER_ATOMIC_EN
  localparam logic [2:0] MASK_IDX = 3'(SLOTS);

  logic        is_slot;
  logic        is_mask;
  logic [31:0] mask_word_q;
  logic        flush_final_q;
  logic        sh_wr_en;
  logic        sh_clr_en;
  logic        sh_any;
  logic [2:0]  sh_first_idx;
  logic [31:0] sh_first_data;

  assign is_slot   = (hdr_idx_q < MASK_IDX);
  assign is_mask   = (hdr_idx_q == MASK_IDX);
  assign sh_wr_en  = (state_q == ST_D3) && accept && is_slot;
  // Each slot's valid bit is consumed as it is loaded for writing.
  assign sh_clr_en = (state_q == ST_FLUSH) && !snes_busy && !flush_final_q && sh_any;

  cheat_loader_shadow #(.SLOTS(SLOTS)) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (sh_wr_en),
    .wr_idx     (hdr_idx_q),
    .wr_data    (word_full),
    .clr_en     (sh_clr_en),
    .clr_idx    (sh_first_idx),
    .any_valid  (sh_any),
    .first_idx  (sh_first_idx),
    .first_data (sh_first_data)
  );
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HDR;
      hdr_idx_q <= '0;
      shift_q   <= '0;
      pgm_idx   <= '0;
      pgm_in    <= '0;
      err       <= 1'b0;
`ifdef CHEAT_LOADER_ATOMIC_EN
      mask_word_q   <= '0;
      flush_final_q <= 1'b0;
`endif
    end else begin
      if (mcu_start)                     err <= 1'b0;
      else if (mcu_valid && !mcu_ready)  err <= 1'b1;

      case (state_q)
        ST_HDR, ST_D0, ST_D1, ST_D2, ST_D3: begin
          if (mcu_start) begin
            state_q <= ST_HDR;
          end else if (accept) begin
            case (state_q)
              ST_HDR: begin
                hdr_idx_q <= mcu_data[2:0];
                state_q   <= ST_D0;
              end
              ST_D0: begin
                shift_q <= {shift_q[15:0], mcu_data};
                state_q <= ST_D1;
              end
              ST_D1: begin
                shift_q <= {shift_q[15:0], mcu_data};
                state_q <= ST_D2;
              end
              ST_D2: begin
                shift_q <= {shift_q[15:0], mcu_data};
                state_q <= ST_D3;
              end
              default: begin
`ifdef CHEAT_LOADER_ATOMIC_EN
                if (is_slot) begin
                  state_q <= ST_HDR;
                end else if (is_mask) begin
                  // Flush opens by disabling every patch before slots change.
                  mask_word_q   <= word_full;
                  flush_final_q <= 1'b0;
                  pgm_idx       <= hdr_idx_q;
                  pgm_in        <= '0;
                  state_q       <= ST_FLUSH;
                end else begin
                  pgm_idx <= hdr_idx_q;
                  pgm_in  <= word_full;
                  state_q <= ST_ISSUE;
                end
`else
                pgm_idx <= hdr_idx_q;
                pgm_in  <= word_full;
                state_q <= ST_ISSUE;
`endif
              end
            endcase
          end
        end

        ST_ISSUE: begin
          if (!snes_busy) state_q <= ST_HDR;
        end

`ifdef CHEAT_LOADER_ATOMIC_EN
        ST_FLUSH: begin
          if (!snes_busy) begin
            if (flush_final_q) begin
              state_q <= ST_HDR;
            end else if (sh_any) begin
              pgm_idx <= sh_first_idx;
              pgm_in  <= sh_first_data;
            end else begin
              pgm_idx       <= MASK_IDX;
              pgm_in        <= mask_word_q;
              flush_final_q <= 1'b1;
            end
          end
        end
`endif

        default: state_q <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_cheat_loader.sv
// Self-checking bench for cheat_loader: per-cycle vector table for framing,
// busy deferral, overrun and resync, plus sequences for reset and atomic flush.
module tb_cheat_loader;
  import cheat_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mcu_start;
  logic        mcu_valid;
  logic [7:0]  mcu_data;
  logic        mcu_ready;
  logic        snes_busy;
  logic [2:0]  pgm_idx;
  logic [31:0] pgm_in;
  logic        pgm_we;
  logic        err;

  cheat_loader #(.SLOTS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mcu_start (mcu_start),
    .mcu_valid (mcu_valid),
    .mcu_data  (mcu_data),
    .mcu_ready (mcu_ready),
    .snes_busy (snes_busy),
    .pgm_idx   (pgm_idx),
    .pgm_in    (pgm_in),
    .pgm_we    (pgm_we),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int busy_viol = 0;

  logic [2:0]  ev_idx [$];
  logic [31:0] ev_word[$];

  always @(negedge clk) begin
    if (rst_n && pgm_we) begin
      ev_idx.push_back(pgm_idx);
      ev_word.push_back(pgm_in);
      if (snes_busy) busy_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  d;
    logic        bz;
    logic        rdy;
    logic        we;
    logic        er;
    logic        cw;
    logic [2:0]  idx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic vl, input logic [7:0] d,
                              input logic bz, input logic rdy, input logic we,
                              input logic er, input logic cw, input logic [2:0] idx,
                              input logic [31:0] word);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d; v.bz = bz; v.rdy = rdy; v.we = we;
    v.er = er; v.cw = cw; v.idx = idx; v.word = word;
    vecs.push_back(v);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    mcu_valid = 1'b1;
    mcu_data  = b;
    @(posedge clk); #1;
    mcu_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] hdr, input logic [31:0] w);
    send_byte(hdr);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_events(input int n);
    for (int i = 0; i < 30 && ev_idx.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_event(input int i, input logic [2:0] idx, input logic [31:0] w);
    check($sformatf("ev%0d_idx", i), (i < ev_idx.size())  ? 32'(ev_idx[i]) : 32'hDEAD_DEAD, 32'(idx));
    check($sformatf("ev%0d_word", i), (i < ev_word.size()) ? ev_word[i]     : 32'hDEAD_DEAD, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w_a;
    logic [31:0] w_b;
    rst_n = 1'b0; mcu_start = 1'b0; mcu_valid = 1'b0; mcu_data = '0; snes_busy = 1'b0;
    w_a = make_slot_word(24'h7E1234, 8'hA9);
    w_b = make_flags_word(6'h00, 6'h01);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef CHEAT_LOADER_ATOMIC_EN
    // st vl  data  bz | rdy we er | cw idx word
    add(0, 1, 8'h00, 0, 1, 0, 0, 1, 3'd0, 32'h0);          // reset values
    add(0, 1, 8'h7E, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h12, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h34, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hA9, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 3'd0, w_a);            // strobe N+1
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, 3'd0, w_a);            // ready after we
    add(0, 1, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h7E, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h12, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h34, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hA9, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 8'h00, 1, 0, 0, 0, 1, 3'd0, w_a);          // deferred, held
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 3'd0, w_a);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h05, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hDE, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hAD, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hBE, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hEF, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h55, 0, 0, 1, 0, 1, 3'd5, 32'hDEADBEEF);   // byte during ISSUE
    add(0, 0, 8'h00, 0, 1, 0, 1, 1, 3'd5, 32'hDEADBEEF);   // overrun sticky
    add(1, 1, 8'h33, 0, 1, 0, 1, 0, 3'd0, 32'h0);          // start beats byte
    add(0, 1, 8'h02, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h01, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h02, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h03, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h04, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 3'd2, 32'h01020304);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h01, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hAA, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'hBB, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 1, 3'd2, 32'h01020304);   // resync mid-word
    add(0, 1, 8'h07, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h00, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 1, 8'h01, 0, 1, 0, 0, 0, 3'd0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 3'd7, w_b);
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, 3'd7, w_b);

    foreach (vecs[k]) begin
      mcu_start = vecs[k].st;
      mcu_valid = vecs[k].vl;
      mcu_data  = vecs[k].d;
      snes_busy = vecs[k].bz;
      @(negedge clk);
      check($sformatf("v%0d_ready", k), 32'(mcu_ready), 32'(vecs[k].rdy));
      check($sformatf("v%0d_we", k),    32'(pgm_we),    32'(vecs[k].we));
      check($sformatf("v%0d_err", k),   32'(err),       32'(vecs[k].er));
      if (vecs[k].cw) begin
        check($sformatf("v%0d_idx", k),  32'(pgm_idx), 32'(vecs[k].idx));
        check($sformatf("v%0d_word", k), pgm_in,       vecs[k].word);
      end
      @(posedge clk); #1;
    end
    mcu_start = 1'b0; mcu_valid = 1'b0; snes_busy = 1'b0;

    // Reset while a write is pending: outputs drop at once, write is lost.
    send_word(8'h04, 32'h11223344);
    snes_busy = 1'b1; mcu_valid = 1'b1; mcu_data = 8'h99;
    @(posedge clk); #1;
    mcu_valid = 1'b0; snes_busy = 1'b0;
    #1;
    check("rst_pre_we", 32'(pgm_we), 32'd1);
    check("rst_pre_err", 32'(err), 32'd1);
    ev_idx.delete(); ev_word.delete();
    rst_n = 1'b0;
    #1;
    check("rst_we", 32'(pgm_we), 32'd0);
    check("rst_idx", 32'(pgm_idx), 32'd0);
    check("rst_word", pgm_in, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ready", 32'(mcu_ready), 32'd1);
    check("rst_no_replay", 32'(ev_idx.size()), 32'd0);
    @(posedge clk); #1;
`else
    // Atomic mode: slots 2 then 0 are buffered, the mask word flushes them.
    ev_idx.delete(); ev_word.delete();
    send_word(8'h02, 32'h00102033);
    send_word(8'h00, w_a);
    repeat (3) @(posedge clk);
    #1;
    check("at_no_early_we", 32'(ev_idx.size()), 32'd0);
    send_word(8'h06, 32'h00000005);
    snes_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("at_flush_ready", 32'(mcu_ready), 32'd0);
      check("at_flush_stall", 32'(pgm_we), 32'd0);
      @(posedge clk); #1;
    end
    snes_busy = 1'b0;
    wait_events(4);
    @(negedge clk);
    check("at_ready_after", 32'(mcu_ready), 32'd1);
    check("at_ev_count", 32'(ev_idx.size()), 32'd4);
    check_event(0, 3'd6, 32'h0);
    check_event(1, 3'd0, w_a);
    check_event(2, 3'd2, 32'h00102033);
    check_event(3, 3'd6, 32'h00000005);
    @(posedge clk); #1;

    // Flags word bypasses the shadow store.
    ev_idx.delete(); ev_word.delete();
    send_word(8'h07, w_b);
    wait_events(1);
    check("at_flags_count", 32'(ev_idx.size()), 32'd1);
    check_event(0, 3'd7, w_b);

    // Reset during FLUSH clears the valid bits.
    send_word(8'h01, 32'h00ABCDEF);
    snes_busy = 1'b1;
    send_word(8'h06, 32'h0000003F);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("atr_we", 32'(pgm_we), 32'd0);
    check("atr_idx", 32'(pgm_idx), 32'd0);
    check("atr_word", pgm_in, 32'd0);
    check("atr_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snes_busy = 1'b0;
    ev_idx.delete(); ev_word.delete();
    send_word(8'h06, 32'h00000003);
    wait_events(2);
    repeat (4) @(posedge clk);
    #1;
    check("atr_ev_count", 32'(ev_idx.size()), 32'd2);
    check_event(0, 3'd6, 32'h0);
    check_event(1, 3'd6, 32'h00000003);
`endif

    check("we_vs_busy", 32'(busy_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
